// File: rtl/alarm_trigger_if.sv
// Alarm trigger bundle: time-of-day, alarm setting and user controls in, ring status and flasher start out.
// The master side is the clock/keypad logic; the slave side is alarm_trigger.
interface alarm_trigger_if;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic       trig;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_left;

  modport master (
    output sec_tick, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
           alarm_en, snooze, dismiss,
    input  trig, ringing, snoozing, snooze_left
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
           alarm_en, snooze, dismiss,
    output trig, ringing, snoozing, snooze_left
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm session FSM (idle/ring/snooze) emitting one-cycle flasher start pulses; all outputs registered,
// one cycle after the deciding input. No backpressure: trig is a fire-and-forget pulse.
module alarm_trigger #(
  parameter int RETRIG_SEC = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CW         = 9
) (
  input  logic          clk,
  input  logic          rst,
  alarm_trigger_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RING   = 2'd1;
  localparam logic [1:0] SNOOZE = 2'd2;

  localparam logic [CW-1:0] RT_LAST  = CW'(RETRIG_SEC - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNZ_LAST = CW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    LEFT_MAX = 2'(MAX_SNOOZE);

  logic [1:0]    state, state_n;
  logic [CW-1:0] rt_cnt, rt_n;
  logic [CW-1:0] run_cnt, run_n;
  logic [1:0]    left_q, left_n;
  logic          trig_q, trig_n;
  logic          ringing_q, snoozing_q;
  logic          match, abort, to_idle;

  assign match = bus.alarm_en & bus.sec_tick &
                 (bus.cur_hour == bus.alarm_hour) &
                 (bus.cur_min == bus.alarm_min) &
                 (bus.cur_sec == 6'd0);

  // Disarm or dismiss beats every other event in a live session.
  assign abort = ~bus.alarm_en | bus.dismiss;

  always_comb begin
    state_n = state;
    rt_n    = rt_cnt;
    run_n   = run_cnt;
    left_n  = left_q;
    trig_n  = 1'b0;
    to_idle = 1'b0;
    case (state)
      IDLE: begin
        if (match) begin
          state_n = RING;
          trig_n  = 1'b1;
          rt_n    = '0;
          run_n   = '0;
        end
      end
      RING: begin
        if (abort) begin
          to_idle = 1'b1;
        end else if (bus.sec_tick && run_cnt == RUN_LAST) begin
          to_idle = 1'b1;
        end else if (bus.snooze && left_q != 2'd0) begin
          state_n = SNOOZE;
          left_n  = left_q - 2'd1;
          run_n   = '0;
        end else if (bus.sec_tick) begin
          run_n = run_cnt + 1'b1;
          if (rt_cnt == RT_LAST) begin
            trig_n = 1'b1;
            rt_n   = '0;
          end else begin
            rt_n = rt_cnt + 1'b1;
          end
        end
      end
      SNOOZE: begin
        if (abort) begin
          to_idle = 1'b1;
        end else if (bus.sec_tick) begin
          if (run_cnt == SNZ_LAST) begin
            state_n = RING;
            trig_n  = 1'b1;
            rt_n    = '0;
            run_n   = '0;
          end else begin
            run_n = run_cnt + 1'b1;
          end
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_n = IDLE;
      left_n  = LEFT_MAX;
      rt_n    = '0;
      run_n   = '0;
      trig_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rt_cnt     <= '0;
      run_cnt    <= '0;
      left_q     <= LEFT_MAX;
      trig_q     <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state      <= state_n;
      rt_cnt     <= rt_n;
      run_cnt    <= run_n;
      left_q     <= left_n;
      trig_q     <= trig_n;
      ringing_q  <= (state_n == RING);
      snoozing_q <= (state_n == SNOOZE);
    end
  end

  assign bus.trig        = trig_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_left = left_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: instance A (RETRIG=2) covers the main scenarios,
// instance B (RETRIG=3) sees the same inputs to exercise the retrigger/timeout collision.
module tb_alarm_trigger;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   trig_cnt_a;
  int   trig_cnt_b;
  int   c0;
  int   b0;

  alarm_trigger_if ifa ();
  alarm_trigger_if ifb ();

  assign ifb.sec_tick   = ifa.sec_tick;
  assign ifb.cur_hour   = ifa.cur_hour;
  assign ifb.cur_min    = ifa.cur_min;
  assign ifb.cur_sec    = ifa.cur_sec;
  assign ifb.alarm_hour = ifa.alarm_hour;
  assign ifb.alarm_min  = ifa.alarm_min;
  assign ifb.alarm_en   = ifa.alarm_en;
  assign ifb.snooze     = ifa.snooze;
  assign ifb.dismiss    = ifa.dismiss;

  alarm_trigger #(.RETRIG_SEC(2), .RING_SEC(6), .SNOOZE_SEC(3), .MAX_SNOOZE(2), .CW(9)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  alarm_trigger #(.RETRIG_SEC(3), .RING_SEC(6), .SNOOZE_SEC(3), .MAX_SNOOZE(2), .CW(9)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.trig === 1'b1) trig_cnt_a <= trig_cnt_a + 1;
    if (ifb.trig === 1'b1) trig_cnt_b <= trig_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ifa.sec_tick = 1'b1;
    step(1);
    ifa.sec_tick = 1'b0;
  endtask

  // Alarm-time tick with cur_sec=0, then move the clock on so later ticks do not match.
  task automatic match_tick();
    ifa.cur_sec = 6'd0;
    tick();
    ifa.cur_sec = 6'd1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    trig_cnt_a = 0;
    trig_cnt_b = 0;
    rst            = 1'b0;
    ifa.sec_tick   = 1'b0;
    ifa.cur_hour   = 5'd7;
    ifa.cur_min    = 6'd29;
    ifa.cur_sec    = 6'd59;
    ifa.alarm_hour = 5'd7;
    ifa.alarm_min  = 6'd30;
    ifa.alarm_en   = 1'b1;
    ifa.snooze     = 1'b0;
    ifa.dismiss    = 1'b0;
    step(3);

    chk("rst_trig", ifa.trig, 0);
    chk("rst_ringing", ifa.ringing, 0);
    chk("rst_snoozing", ifa.snoozing, 0);
    chk("rst_snooze_left", ifa.snooze_left, 2);
    rst = 1'b1;
    step(2);

    // Minute before the alarm: no match.
    tick();
    chk("pre_alarm_trig", ifa.trig, 0);
    step(1);

    // Basic ring: trig at T+1, after ticks 2 and 4, timeout at tick 6.
    ifa.cur_min = 6'd30;
    c0 = trig_cnt_a;
    b0 = trig_cnt_b;
    match_tick();
    chk("match_ringing", ifa.ringing, 1);
    chk("match_trig", ifa.trig, 1);
    chk("b_match_trig", ifb.trig, 1);
    step(1);
    chk("trig_one_cycle", ifa.trig, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) begin
        chk($sformatf("ring_tick%0d_trig", i), ifa.trig, (i % 2 == 0) ? 8'd1 : 8'd0);
        chk($sformatf("ring_tick%0d_ringing", i), ifa.ringing, 1);
        chk($sformatf("b_tick%0d_trig", i), ifb.trig, (i == 3) ? 8'd1 : 8'd0);
      end
      step(1);
    end
    chk("timeout_ringing", ifa.ringing, 0);
    chk("timeout_trig_count", 8'(trig_cnt_a - c0), 3);
    chk("b_timeout_ringing", ifb.ringing, 0);
    chk("b_collision_trig_count", 8'(trig_cnt_b - b0), 2);

    // Snooze cycle.
    match_tick();
    chk("snz_match_ringing", ifa.ringing, 1);
    step(1);
    ifa.snooze = 1'b1;
    tick();
    ifa.snooze = 1'b0;
    chk("snz1_snoozing", ifa.snoozing, 1);
    chk("snz1_ringing", ifa.ringing, 0);
    chk("snz1_left", ifa.snooze_left, 1);
    chk("snz1_trig", ifa.trig, 0);
    step(1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("snz1_tick%0d_ringing", i), ifa.ringing, (i == 3) ? 8'd1 : 8'd0);
      chk($sformatf("snz1_tick%0d_trig", i), ifa.trig, (i == 3) ? 8'd1 : 8'd0);
      step(1);
    end
    ifa.snooze = 1'b1;
    step(1);
    chk("snz2_snoozing", ifa.snoozing, 1);
    chk("snz2_left", ifa.snooze_left, 0);
    // Held snooze stays ignored while snoozing.
    step(1);
    ifa.snooze = 1'b0;
    chk("snz2_held_left", ifa.snooze_left, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      step(1);
    end
    chk("snz2_resume_ringing", ifa.ringing, 1);
    ifa.snooze = 1'b1;
    step(1);
    ifa.snooze = 1'b0;
    chk("snz3_ignored_ringing", ifa.ringing, 1);
    chk("snz3_ignored_snoozing", ifa.snoozing, 0);
    chk("snz3_left", ifa.snooze_left, 0);

    // Dismiss alone reloads snooze_left.
    ifa.dismiss = 1'b1;
    step(1);
    ifa.dismiss = 1'b0;
    chk("dismiss_ringing", ifa.ringing, 0);
    chk("dismiss_left_reload", ifa.snooze_left, 2);
    step(1);

    // Dismiss beats snooze in the same cycle.
    match_tick();
    step(1);
    c0 = trig_cnt_a;
    ifa.snooze  = 1'b1;
    ifa.dismiss = 1'b1;
    step(1);
    ifa.snooze  = 1'b0;
    ifa.dismiss = 1'b0;
    chk("dis_pri_ringing", ifa.ringing, 0);
    chk("dis_pri_snoozing", ifa.snoozing, 0);
    chk("dis_pri_trig", ifa.trig, 0);
    chk("dis_pri_left", ifa.snooze_left, 2);
    step(2);
    chk("dis_pri_trig_count", 8'(trig_cnt_a - c0), 0);

    // Disarm during snooze.
    match_tick();
    step(1);
    ifa.snooze = 1'b1;
    step(1);
    ifa.snooze = 1'b0;
    chk("disarm_pre_snoozing", ifa.snoozing, 1);
    ifa.alarm_en = 1'b0;
    step(1);
    chk("disarm_snoozing", ifa.snoozing, 0);
    chk("disarm_ringing", ifa.ringing, 0);
    chk("disarm_left", ifa.snooze_left, 2);

    // No-match cases.
    c0 = trig_cnt_a;
    ifa.cur_sec = 6'd0;
    tick();
    chk("nomatch_disabled_ringing", ifa.ringing, 0);
    ifa.alarm_en = 1'b1;
    ifa.cur_sec  = 6'd1;
    tick();
    chk("nomatch_sec1_trig", ifa.trig, 0);
    ifa.cur_sec = 6'd0;
    step(2);
    chk("nomatch_notick_ringing", ifa.ringing, 0);
    ifa.cur_min = 6'd31;
    tick();
    chk("nomatch_min_ringing", ifa.ringing, 0);
    ifa.cur_min = 6'd30;
    ifa.cur_sec = 6'd1;
    step(2);
    chk("nomatch_trig_count", 8'(trig_cnt_a - c0), 0);

    // Async reset between edges while ringing, then while snoozing.
    match_tick();
    chk("ar_pre_trig", ifa.trig, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_ring_trig", ifa.trig, 0);
    chk("ar_ring_ringing", ifa.ringing, 0);
    #1 rst = 1'b1;
    step(2);
    match_tick();
    step(1);
    ifa.snooze = 1'b1;
    step(1);
    ifa.snooze = 1'b0;
    chk("ar_pre_left", ifa.snooze_left, 1);
    #3 rst = 1'b0;
    #1;
    chk("ar_snz_snoozing", ifa.snoozing, 0);
    chk("ar_snz_left", ifa.snooze_left, 2);
    #1 rst = 1'b1;
    step(2);
    c0 = trig_cnt_a;
    for (int i = 0; i < 4; i++) begin
      tick();
      step(1);
    end
    chk("ar_after_ringing", ifa.ringing, 0);
    chk("ar_after_trig_count", 8'(trig_cnt_a - c0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
